// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: show-ahead FIFO of {instr, pc, next_pc}
// entries, flushed wholesale on a ROB mispredict.
module instr_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_next_pc,
  output logic             iq_ready,
  output logic             iq_valid,
  output logic [31:0]      iq_instr,
  output logic [31:0]      iq_pc,
  output logic [31:0]      iq_next_pc,
  input  logic             dispatch_ack,
  output logic             iq_ir_ack,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [95:0]      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count_next;
  logic [95:0]      head_entry;
  logic             enq;
  logic             deq;

  // Occupancy flags come straight from the count register, so an async reset empties them at once
  always_comb begin
    full     = (count == FULL_COUNT);
    empty    = (count == '0);
    iq_ready = !full;
    iq_valid = !empty;
  end

  // Handshakes; reset also gates the fetch acknowledge
  always_comb begin
    enq       = fetch_valid & iq_ready & !flush & !rst;
    deq       = dispatch_ack & iq_valid & !flush;
    iq_ir_ack = enq;
  end

  // Show-ahead head entry
  always_comb begin
    head_entry = mem[head_ptr];
    iq_instr   = head_entry[95:64];
    iq_pc      = head_entry[63:32];
    iq_next_pc = head_entry[31:0];
  end

  // Next occupancy from the enqueue/dequeue pair
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + ONE_COUNT;
      2'b01:   count_next = count - ONE_COUNT;
      default: count_next = count;
    endcase
  end

  // Entry storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail_ptr] <= {fetch_instr, fetch_pc, fetch_next_pc};
    end
  end

  // Pointers and occupancy; flush outranks both handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        tail_ptr <= tail_ptr + ONE_PTR;
      end
      if (deq) begin
        head_ptr <= head_ptr + ONE_PTR;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_instr = 32'h0;
  logic [31:0] fetch_pc = 32'h0;
  logic [31:0] fetch_next_pc = 32'h0;
  logic        dispatch_ack = 1'b0;
  logic        iq_ready, iq_valid, iq_ir_ack, full, empty;
  logic [31:0] iq_instr, iq_pc, iq_next_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [95:0] q[$];
  int ack_seen = 0;
  int disp_n = 0;
  bit stream_on = 1'b0;
  bit have_disp = 1'b0;
  logic [31:0] last_disp = 32'h0;
  int base;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_next_pc(fetch_next_pc), .iq_ready(iq_ready), .iq_valid(iq_valid),
    .iq_instr(iq_instr), .iq_pc(iq_pc), .iq_next_pc(iq_next_pc),
    .dispatch_ack(dispatch_ack), .iq_ir_ack(iq_ir_ack), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model; called mid-cycle with inputs stable
  task automatic compare();
    logic exp_ack;
    exp_ack = fetch_valid && !flush && !rst && (q.size() < DEPTH);
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("iq_valid", 32'(iq_valid), 32'(q.size() != 0));
    chk("iq_ready", 32'(iq_ready), 32'(q.size() < DEPTH));
    chk("iq_ir_ack", 32'(iq_ir_ack), 32'(exp_ack));
    if (q.size() != 0) begin
      chk("iq_instr", iq_instr, q[0][95:64]);
      chk("iq_pc", iq_pc, q[0][63:32]);
      chk("iq_next_pc", iq_next_pc, q[0][31:0]);
    end
    chk("inv_count_le_depth", 32'(count <= 4'(DEPTH)), 32'd1);
    chk("inv_full_empty", 32'(full && empty), 32'd0);
    chk("inv_valid_count", 32'(iq_valid), 32'(count != 4'd0));
    if (iq_ir_ack) ack_seen++;
    if (!stream_on) begin
      have_disp = 1'b0;
    end else if (dispatch_ack && iq_valid && !flush && !rst) begin
      if (have_disp) chk("stream_pc_step", iq_pc, last_disp + 32'd4);
      last_disp = iq_pc;
      have_disp = 1'b1;
      disp_n++;
    end
  endtask

  // Reference model: strict FIFO, flush/reset empty it, full rejects fetch even with a dequeue
  task automatic model_step();
    bit d, e;
    if (rst || flush) begin
      q.delete();
    end else begin
      d = dispatch_ack && (q.size() != 0);
      e = fetch_valid && (q.size() < DEPTH);
      if (d) void'(q.pop_front());
      if (e) q.push_back({fetch_instr, fetch_pc, fetch_next_pc});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_pc      = pc;
    fetch_instr   = instr;
    fetch_next_pc = pc + 32'd4;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid = 1'b1;
    set_fetch(pc, instr);
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    fork
      forever begin @(negedge clk); compare(); end
      forever begin @(posedge clk); model_step(); end
      forever begin @(posedge rst); q.delete(); end
    join_none

    // Reset state
    step();
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_iq_valid", 32'(iq_valid), 32'd0);
    chk("rst_iq_ready", 32'(iq_ready), 32'd1);
    step();
    rst = 1'b0;

    // Three enqueues, no dispatch
    base = ack_seen;
    push(32'h60, 32'h00A00093);
    push(32'h64, 32'h00108113);
    push(32'h68, 32'h002081B3);
    @(negedge clk);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_pc", iq_pc, 32'h60);
    chk("t1_instr", iq_instr, 32'h00A00093);
    chk("t1_next_pc", iq_next_pc, 32'h64);
    chk("t1_acks", 32'(ack_seen - base), 32'd3);

    // Fill past capacity
    do_flush();
    base = ack_seen;
    fetch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_fetch(32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      step();
    end
    fetch_valid = 1'b0;
    @(negedge clk);
    chk("fill_acks", 32'(ack_seen - base), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(iq_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_head_pc", iq_pc, 32'h100);

    // Steady stream across pointer wrap
    do_flush();
    push(32'h300, 32'h2000);
    base = disp_n;
    stream_on = 1'b1;
    fetch_valid = 1'b1;
    dispatch_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_fetch(32'h304 + 32'(4 * i), 32'h2001 + 32'(i));
      step();
    end
    fetch_valid = 1'b0;
    dispatch_ack = 1'b0;
    @(negedge clk);
    stream_on = 1'b0;
    chk("stream_dispatches", 32'(disp_n - base), 32'd20);
    chk("stream_last_pc", last_disp, 32'h34C);
    chk("stream_count", 32'(count), 32'd1);
    chk("stream_head_pc", iq_pc, 32'h350);

    // Dispatch ack while empty
    do_flush();
    dispatch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ackempty_count", 32'(count), 32'd0);
      chk("ackempty_empty", 32'(empty), 32'd1);
      chk("ackempty_valid", 32'(iq_valid), 32'd0);
      step();
    end
    dispatch_ack = 1'b0;

    // Flush beats simultaneous enqueue and dequeue
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(4 * i), 32'h3000 + 32'(i));
    flush = 1'b1;
    fetch_valid = 1'b1;
    dispatch_ack = 1'b1;
    set_fetch(32'h500, 32'h4000);
    @(negedge clk);
    chk("flush_no_ack", 32'(iq_ir_ack), 32'd0);
    step();
    flush = 1'b0;
    fetch_valid = 1'b0;
    dispatch_ack = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(iq_valid), 32'd0);
    push(32'h200, 32'h5000);
    @(negedge clk);
    chk("flush_refill_pc", iq_pc, 32'h200);
    chk("flush_refill_count", 32'(count), 32'd1);

    // Async reset between edges
    do_flush();
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i), 32'h6000 + 32'(i));
    @(posedge clk);
    #3;
    rst = 1'b1;
    fetch_valid = 1'b1;
    set_fetch(32'h680, 32'h6800);
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_valid", 32'(iq_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_no_ack", 32'(iq_ir_ack), 32'd0);
    step();
    rst = 1'b0;
    fetch_valid = 1'b0;
    chk("arst_tail0", 32'(dut.tail_ptr), 32'd0);
    chk("arst_head0", 32'(dut.head_ptr), 32'd0);
    push(32'h700, 32'h7000);
    @(negedge clk);
    chk("arst_tail1", 32'(dut.tail_ptr), 32'd1);
    chk("arst_head_pc", iq_pc, 32'h700);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- FIFO instruction queue between the fetch/IR stage and the issue/dispatch logic of the Tomasulo core.
- Captures fetched instruction words with their PC and predicted next PC.
- Presents the oldest entry to dispatch, which dequeues it with an acknowledge once a reservation station, ROB slot and LSQ slot are secured.
- Flushed wholesale on a branch/JALR mispredict signalled by the ROB.

Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  ROB mispredict flush; empties the queue.
- fetch_valid  in  1  fetch presents a valid instruction this cycle.
- fetch_instr  in  32  instruction word.
- fetch_pc  in  32  PC of the instruction.
- fetch_next_pc  in  32  predicted next PC.
- iq_ready  out  1  queue can accept; equals !full.
- iq_valid  out  1  head entry valid; equals !empty.
- iq_instr  out  32  head instruction, show-ahead.
- iq_pc  out  32  head PC.
- iq_next_pc  out  32  head predicted next PC.
- dispatch_ack  in  1  dispatch consumes the head entry this cycle.
- iq_ir_ack  out  1  pulse; fetch entry accepted this cycle; fetch may advance PC.
- count  out  PTR_W+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH x 96-bit array {instr, pc, next_pc}.
- Pointers: head_ptr and tail_ptr, PTR_W bits each, wrapping modulo DEPTH. Count register is PTR_W+1 bits.
- Reset (async, rst=1): head_ptr=0, tail_ptr=0, count=0.
  - Outputs during and after reset: empty=1, full=0, iq_valid=0, iq_ready=1, iq_ir_ack=0.
  - Data array is not reset.
  - iq_instr/iq_pc/iq_next_pc are don't-care while iq_valid=0.
- enq = fetch_valid & iq_ready & !flush.
- deq = dispatch_ack & iq_valid & !flush.
- iq_ir_ack = enq. It is combinational, same cycle as the handshake.
- On enq:
  - array[tail_ptr] <= fetch data;
  - tail_ptr <= tail_ptr+1.
- On deq: head_ptr <= head_ptr+1.
- Count update: enq only -> +1; deq only -> -1; both or neither -> unchanged.
- Simultaneous enq and deq while partially full: both occur and count is unchanged.
- When full, iq_ready=0. An enqueue in the same cycle as a dequeue is not accepted; fetch retries next cycle.
- When empty, iq_valid=0. dispatch_ack is ignored; count stays 0 and there is no underflow.
- Head outputs read combinationally from array[head_ptr] (show-ahead).
  - An entry written at edge N is visible on iq_* after edge N.
  - Minimum enqueue-to-dispatch latency is one cycle; there is no write-through bypass.
- Flush has priority over enq and deq.
  - At the next edge: head_ptr <= 0, tail_ptr <= 0, count <= 0.
  - iq_ir_ack=0 during the flush cycle.
  - iq_valid=0 from the cycle after the flush.
  - Flush held across multiple cycles keeps the queue empty.
- Pointer wrap: DEPTH-1 -> 0; no lost entries across the wrap.
- Reset mid-operation: immediate return to the reset state regardless of clock.
  - Entries in flight are discarded.
  - No iq_ir_ack asserts while rst=1.
- Ordering: strict FIFO. Entries leave in fetch order with their {pc, next_pc} pairing intact.
- Assertions for the bench:
  - count <= DEPTH always.
  - full & empty never both 1.
  - iq_valid == (count != 0).

Test Plan:
- Reset, then enqueue 3 instrs: pc=0x60, 0x64, 0x68; instr=0x00A00093, 0x00108113, 0x002081B3; no ack. -> count=3; head shows pc=0x60, instr=0x00A00093, next_pc=0x64; iq_ir_ack high for 3 cycles.
- Fill: fetch_valid held for 10 cycles with no ack (DEPTH=8). -> exactly 8 iq_ir_ack pulses; full=1; iq_ready=0 from the cycle after the 8th accept; entries 9 and 10 not accepted.
- Steady stream: fetch_valid and dispatch_ack both held for 20 cycles after 1 preload. -> count stays 1; dispatched PCs strictly increase by 4; pointers wrap past 7 with no gaps.
- Ack when empty: after reset, dispatch_ack=1 for 3 cycles, no fetch. -> count=0; empty=1; iq_valid=0 throughout.
- Flush with simultaneous enq and deq: 5 entries queued; on one cycle assert flush, fetch_valid and dispatch_ack together. -> iq_ir_ack=0 that cycle; next cycle count=0, iq_valid=0; the following enqueue of pc=0x200 appears at head with pc=0x200.
- Async reset mid-stream: 4 entries queued; assert rst between clock edges. -> empty=1 and iq_valid=0 immediately, before the next edge; after release the first enqueue lands at slot 0.
